// File: rtl/serial_subtract.sv
// serial_subtract: bit-serial two's-complement subtractor, D = A - B - BI.
// A single full-subtractor cell and a registered borrow process one bit per
// cycle, LSB first, so a WIDTH-bit difference takes WIDTH cycles of RUN.
//
// State table:
//   state | meaning
//   IDLE  | waiting for an operand bundle, in_ready = 1
//   RUN   | one difference bit per cycle, cnt tracks the bit index
//   DONE  | result held on d/bo/v/z with out_valid = 1 until out_ready
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake for a, b, bi
//   out_valid / out_ready result handshake for d, bo, v, z
//   d   difference mod 2^WIDTH
//   bo  borrow out (unsigned a < b + bi)
//   v   signed overflow
//   z   d == 0
module serial_subtract #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             v,
  output logic             z
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] sa, sb, sd, sd_n;
  logic [WIDTH-1:0] d_r;
  logic             br, br_n;
  logic             bo_r, v_r, z_r;
  logic [CW-1:0]    cnt;
  logic             x, dbit, last, load;

  // Full-subtractor cell on the current LSB.
  assign x    = sa[0] ^ sb[0];
  assign dbit = x ^ br;
  assign br_n = (~sa[0] & sb[0]) | (~x & br);
  assign sd_n = {dbit, sd[WIDTH-1:1]};
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      sd   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      d_r  <= '0;
      bo_r <= 1'b0;
      v_r  <= 1'b0;
      z_r  <= 1'b0;
    end else if (load) begin
      sa  <= a;
      sb  <= b;
      sd  <= '0;
      br  <= bi;
      cnt <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      sd <= sd_n;
      br <= br_n;
      if (last) begin
        // On the MSB step br is still the borrow into the MSB, so the
        // overflow flag is that borrow xor the borrow leaving the MSB.
        d_r  <= sd_n;
        bo_r <= br_n;
        v_r  <= br ^ br_n;
        z_r  <= (sd_n == '0);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign d  = d_r;
  assign bo = bo_r;
  assign v  = v_r;
  assign z  = z_r;

endmodule

// File: tb/tb_serial_subtract.sv
module tb_serial_subtract;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             v;
  logic             z;

  int checks   = 0;
  int failures = 0;

  serial_subtract #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bo        (bo),
    .v         (v),
    .z         (z)
  );

  always #5 clk = ~clk;

  // Presents one operand bundle at a negedge; reports whether in_ready was
  // high there, then drops in_valid just after the accept edge.
  task automatic start_op(input logic [7:0] ia, input logic [7:0] ib,
                          input logic ibi, output logic rdy);
    @(negedge clk);
    a = ia; b = ib; bi = ibi; in_valid = 1'b1;
    #1 rdy = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts negedges after the accept edge until out_valid, bounded.
  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) break;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 8'hAA; b = 8'h55; bi = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_d got=%h exp=00", d); end
    checks++; if ({bo, v, z} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bo, v, z}); end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [7:0] va  [6] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h10, 8'h00};
    logic [7:0] vb  [6] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h0F, 8'h00};
    logic       vbi [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] ed  [6] = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'h00, 8'hFF};
    logic       ebo [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       ev  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       ez  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic rdy;
    int   lat;
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i], vbi[i], rdy);
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL vec%0d_accept in_ready=%b exp=1", i, rdy); end
      wait_result(lat);
      checks++; if (lat != 9 || out_valid !== 1'b1) begin failures++; $display("FAIL vec%0d_latency got=%0d valid=%b exp=9", i, lat, out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL vec%0d_ready_with_valid in_ready=%b exp=0", i, in_ready); end
      checks++; if (d !== ed[i]) begin failures++; $display("FAIL vec%0d_d got=%h exp=%h", i, d, ed[i]); end
      checks++; if ({bo, v, z} !== {ebo[i], ev[i], ez[i]}) begin failures++; $display("FAIL vec%0d_flags bo/v/z got=%b exp=%b", i, {bo, v, z}, {ebo[i], ev[i], ez[i]}); end
      release_result();
    end
  endtask

  task automatic test_stall();
    logic rdy;
    int   lat;
    // 0x9C - 0x21 - 1 = 0x7A; signed -100 - 33 - 1 = -134 overflows.
    start_op(8'h9C, 8'h21, 1'b1, rdy);
    wait_result(lat);
    checks++; if (out_valid !== 1'b1 || d !== 8'h7A || {bo, v, z} !== 3'b010) begin failures++; $display("FAIL stall_result valid=%b d=%h bovz=%b exp 1 7a 010", out_valid, d, {bo, v, z}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'(i * 37); b = 8'(i * 11 + 3); bi = i[0];
      #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL stall_hs%0d valid=%b in_ready=%b exp 1 0", i, out_valid, in_ready); end
      checks++; if (d !== 8'h7A || {bo, v, z} !== 3'b010) begin failures++; $display("FAIL stall_hold%0d d=%h bovz=%b exp 7a 010", i, d, {bo, v, z}); end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL stall_release in_ready=%b valid=%b exp 1 0", in_ready, out_valid); end
    checks++; if (d !== 8'h7A || {bo, v, z} !== 3'b010) begin failures++; $display("FAIL stall_keep d=%h bovz=%b exp 7a 010", d, {bo, v, z}); end
  endtask

  task automatic test_abort();
    logic rdy;
    int   lat;
    int   seen;
    start_op(8'h12, 8'h34, 1'b0, rdy);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL abort_in_ready_rst got=%b exp=0", in_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL abort_after in_ready=%b valid=%b exp 1 0", in_ready, out_valid); end
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL abort_no_valid pulses=%0d exp=0", seen); end
    start_op(8'h55, 8'hAA, 1'b0, rdy);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL abort_next_accept in_ready=%b exp=1", rdy); end
    wait_result(lat);
    checks++; if (lat != 9 || d !== 8'hAB || {bo, v, z} !== 3'b110) begin failures++; $display("FAIL abort_next lat=%0d d=%h bovz=%b exp 9 ab 110", lat, d, {bo, v, z}); end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic       rdy;
    int         lat;
    logic [7:0] ra, rb;
    logic       rbi;
    logic [8:0] ref_full;
    int         sdiff;
    logic       ref_v;
    int         nfail;
    nfail = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      ref_full = {1'b0, ra} - {1'b0, rb} - {8'b0, rbi};
      sdiff = int'($signed(ra)) - int'($signed(rb)) - int'(rbi);
      ref_v = (sdiff < -128) || (sdiff > 127);
      start_op(ra, rb, rbi, rdy);
      wait_result(lat);
      checks++;
      if (rdy !== 1'b1 || lat != 9 || out_valid !== 1'b1 || {bo, d} !== ref_full ||
          v !== ref_v || z !== (ref_full[7:0] == 8'h00)) begin
        failures++;
        nfail++;
        if (nfail <= 10)
          $display("FAIL b2b%0d a=%h b=%h bi=%b got rdy=%b lat=%0d bo=%b d=%h v=%b z=%b exp bo=%b d=%h v=%b",
                   i, ra, rb, rbi, rdy, lat, bo, d, v, z, ref_full[8], ref_full[7:0], ref_v);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
